// File: rtl/sram_frame_reader.sv
// sram_frame_reader: reads one frame from a 16-bit async SRAM and streams it as dv/dtype/data tokens.
module sram_frame_reader #(
  parameter int ADDR_WIDTH  = 21,
  parameter int DIM_WIDTH   = 11,
  parameter int HBLANK      = 4,
  parameter int VBLANK      = 16,
  parameter int DTYPE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic                   trigger,
  input  logic                   buf_sel,
  input  logic [ADDR_WIDTH-1:0]  base0,
  input  logic [ADDR_WIDTH-1:0]  base1,
  input  logic [DIM_WIDTH-1:0]   num_cols,
  input  logic [DIM_WIDTH-1:0]   num_rows,
  input  logic [15:0]            ram_datai,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   oeb,
  output logic                   web,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]            datao,
  output logic                   busy,
  output logic                   frame_done
);
  localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL = 0, DT_FRAME_START = 1, DT_FRAME_END = 2,
                                     DT_ROW_START = 3, DT_ROW_END = 4;
  localparam int BW = $clog2((VBLANK > HBLANK ? VBLANK : HBLANK) + 1);
  localparam int CW = DIM_WIDTH > BW ? DIM_WIDTH : BW;
  typedef enum logic [2:0] {IDLE, FS, RS, PIX, RE, HBL, FE, VBL} state_t;
  state_t state, nxt;
  logic pending, go, abort, pix, last_row, tok;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DIM_WIDTH-1:0] cols_l, rows_l, row;
  logic [CW-1:0] cnt;
  logic [DTYPE_WIDTH-1:0] ty, t0, t1;
  logic dv0, dv1, fd0, fd1;
  logic [15:0] dq;
  assign web = 1'b1;
  assign busy = state != IDLE;
  always_comb begin
    go = enable && (trigger || pending);
    abort = !enable && state != IDLE && state != VBL;
    pix = enable && state == PIX;
    last_row = row + DIM_WIDTH'(1) == rows_l;
    nxt = state;
    case (state)
      IDLE:    nxt = go ? FS : IDLE;
      FS:      nxt = (cols_l == '0 || rows_l == '0) ? FE : RS;
      RS:      nxt = PIX;
      PIX:     nxt = cnt == '0 ? RE : PIX;
      RE:      nxt = HBL;
      HBL:     nxt = cnt != '0 ? HBL : last_row ? FE : RS;
      FE:      nxt = VBL;
      VBL:     nxt = cnt == '0 ? IDLE : VBL;
      default: nxt = IDLE;
    endcase
    if (!enable) nxt = IDLE;
    // an abort replaces whatever this state would have emitted with FRAME_END
    tok = abort || state == FS || state == RS || state == PIX || state == RE || state == FE;
    ty = abort ? DT_FRAME_END :
         state == FS ? DT_FRAME_START :
         state == RS ? DT_ROW_START :
         state == RE ? DT_ROW_END :
         state == FE ? DT_FRAME_END : DT_PIXEL;
  end
  always_ff @(posedge clk)
    if (!resetb) begin
      state   <= IDLE;
      pending <= 1'b0;
      ptr     <= '0;
      cols_l  <= '0;
      rows_l  <= '0;
      row     <= '0;
      cnt     <= '0;
    end else begin
      state   <= nxt;
      pending <= enable && (state == IDLE ? 1'b0 : pending | trigger);
      ptr     <= (state == IDLE && go) ? (buf_sel ? base1 : base0) : pix ? ptr + ADDR_WIDTH'(1) : ptr;
      if (state == IDLE && go) begin
        cols_l <= num_cols;
        rows_l <= num_rows;
        row    <= '0;
      end
      if (state == HBL && nxt == RS) row <= row + DIM_WIDTH'(1);
      // cnt holds the remaining cycles of the current timed state, loaded on entry
      cnt <= nxt != state ? (nxt == PIX ? CW'(cols_l) : nxt == HBL ? CW'(HBLANK) : CW'(VBLANK)) - CW'(1)
                          : cnt - CW'(1);
    end
  always_ff @(posedge clk)
    if (!resetb) begin
      dv0        <= 1'b0;
      t0         <= '0;
      fd0        <= 1'b0;
      addr       <= '0;
      oeb        <= 1'b1;
      dv1        <= 1'b0;
      t1         <= '0;
      fd1        <= 1'b0;
      dq         <= '0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      datao      <= '0;
      frame_done <= 1'b0;
    end else begin
      dv0        <= tok;
      t0         <= ty;
      fd0        <= tok && ty == DT_FRAME_END;
      oeb        <= !pix;
      addr       <= pix ? ptr : addr;
      dv1        <= dv0;
      t1         <= t0;
      fd1        <= fd0;
      dq         <= ram_datai;
      dvo        <= dv1;
      frame_done <= fd1;
      dtypeo     <= dv1 ? t1 : dtypeo;
      datao      <= dv1 ? (t1 == DT_PIXEL ? dq : '0) : datao;
    end
endmodule
